// File: rtl/instr_mem_loader.sv
// instr_mem_loader: instruction memory with a latency-1 fetch read port and a byte-serial program loader
// Ports: clk/rst (async, active-high); pc_addr/rd_en in, instr/rd_oob out (fetch side);
// ld_start/ld_len/ld_byte/ld_valid in, ld_ready/ld_done/ld_err/cpu_hold out (loader side).
module instr_mem_loader #(
  parameter int ADDR_W = 10,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_addr,
  input  logic             rd_en,
  output logic [31:0]      instr,
  output logic             rd_oob,
  input  logic             ld_start,
  input  logic [LEN_W-1:0] ld_len,
  input  logic [7:0]       ld_byte,
  input  logic             ld_valid,
  output logic             ld_ready,
  output logic             ld_done,
  output logic             ld_err,
  output logic             cpu_hold
);
  localparam logic [31:0] DEPTH = 32'(1) << ADDR_W;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [LEN_W-1:0] len_q, len_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] byte_cnt_q, byte_cnt_d;
  logic [23:0] asm_q, asm_d;
  logic ld_ready_q, ld_ready_d, ld_err_q, ld_err_d, cpu_hold_q, cpu_hold_d;
  logic [31:0] instr_q;
  logic rd_oob_q;
  logic acc, word_wr, last, start_bad, start_ok, oob;
  logic unused_pc;
  assign unused_pc = ^pc_addr[1:0];
  assign oob = |pc_addr[31:ADDR_W+2];
  assign acc = ld_valid && ld_ready_q;
  assign word_wr = acc && byte_cnt_q == 2'd3;
  assign last = 32'(wr_ptr_q) + 32'd1 == 32'(len_q);
  assign start_bad = state_q == IDLE && ld_start && (ld_len == '0 || 32'(ld_len) > DEPTH);
  assign start_ok = state_q == IDLE && ld_start && !start_bad;
  always_comb begin
    state_d = state_q;
    len_d = start_ok ? ld_len : len_q;
    wr_ptr_d = start_ok ? '0 : word_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    byte_cnt_d = start_ok ? '0 : acc ? byte_cnt_q + 2'd1 : byte_cnt_q;
    asm_d[7:0] = acc && byte_cnt_q == 2'd0 ? ld_byte : asm_q[7:0];
    asm_d[15:8] = acc && byte_cnt_q == 2'd1 ? ld_byte : asm_q[15:8];
    asm_d[23:16] = acc && byte_cnt_q == 2'd2 ? ld_byte : asm_q[23:16];
    if (start_ok) state_d = LOAD;
    if (state_q == LOAD && word_wr && last) state_d = DONE;
    if (state_q == DONE) state_d = IDLE;
    ld_ready_d = state_q == LOAD && !(word_wr && last);
    ld_err_d = start_bad;
    cpu_hold_d = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q <= '0;
      wr_ptr_q <= '0;
      byte_cnt_q <= '0;
      asm_q <= '0;
      ld_ready_q <= 1'b0;
      ld_err_q <= 1'b0;
      cpu_hold_q <= 1'b0;
      instr_q <= '0;
      rd_oob_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      wr_ptr_q <= wr_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q <= asm_d;
      ld_ready_q <= ld_ready_d;
      ld_err_q <= ld_err_d;
      cpu_hold_q <= cpu_hold_d;
      if (cpu_hold_q) begin
        instr_q <= '0;
        rd_oob_q <= 1'b0;
      end else if (rd_en) begin
        instr_q <= oob ? '0 : mem[pc_addr[ADDR_W+1:2]];
        rd_oob_q <= oob;
      end
    end
  end
  always_ff @(posedge clk)
    if (word_wr) mem[wr_ptr_q[ADDR_W-1:0]] <= {ld_byte, asm_q};
  assign instr = instr_q;
  assign rd_oob = rd_oob_q;
  assign ld_ready = ld_ready_q;
  assign ld_done = state_q == DONE;
  assign ld_err = ld_err_q;
  assign cpu_hold = cpu_hold_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: randomized self-checking bench against a word-array memory model
module tb_instr_mem_loader;
  localparam int AW = 6;
  localparam int LW = 16;
  localparam int DEPTH = 1 << AW;
  logic clk = 0, rst = 1;
  logic [31:0] pc_addr = 0;
  logic rd_en = 0;
  logic [31:0] instr;
  logic rd_oob;
  logic ld_start = 0;
  logic [LW-1:0] ld_len = 0;
  logic [7:0] ld_byte = 0;
  logic ld_valid = 0;
  logic ld_ready, ld_done, ld_err, cpu_hold;
  int errs = 0, checks = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_instr = 0;
  logic exp_oob = 0;
  instr_mem_loader #(.ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .rd_en(rd_en), .instr(instr), .rd_oob(rd_oob),
    .ld_start(ld_start), .ld_len(ld_len), .ld_byte(ld_byte), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_done(ld_done), .ld_err(ld_err), .cpu_hold(cpu_hold)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic do_read(input logic [31:0] addr, input logic en);
    rd_en = en;
    pc_addr = addr;
    tick;
    if (en) begin
      exp_oob = (addr >> (AW + 2)) != 0;
      exp_instr = exp_oob ? 32'd0 : ref_mem[addr[AW+1:2]];
    end
    chk("rd_instr", instr, exp_instr);
    chk("rd_oob", {31'd0, rd_oob}, {31'd0, exp_oob});
    rd_en = 0;
  endtask
  task automatic do_err(input int len);
    ld_start = 1;
    ld_len = LW'(len);
    tick;
    ld_start = 0;
    chk("err_pulse", {31'd0, ld_err}, 32'd1);
    chk("err_hold", {31'd0, cpu_hold}, 32'd0);
    chk("err_ready", {31'd0, ld_ready}, 32'd0);
    tick;
    chk("err_clear", {31'd0, ld_err}, 32'd0);
    chk("err_hold2", {31'd0, cpu_hold}, 32'd0);
  endtask
  task automatic do_load(input int n, input int rst_after);
    logic [31:0] w [$];
    logic [31:0] cur;
    logic r;
    int acc, cyc, total;
    total = (rst_after >= 0) ? rst_after : 4 * n;
    for (int i = 0; i < n; i++) w.push_back($urandom);
    ld_start = 1;
    ld_len = LW'(n);
    rd_en = 0;
    tick;
    ld_start = 0;
    chk("hold_rise", {31'd0, cpu_hold}, 32'd1);
    acc = 0;
    cyc = 0;
    while (acc < total && cyc < 20 * n + 100) begin
      r = ld_ready;
      cur = w[acc / 4];
      ld_byte = cur[8 * (acc % 4) +: 8];
      ld_valid = 1'($urandom_range(0, 1));
      rd_en = 1'($urandom_range(0, 1));
      pc_addr = $urandom;
      ld_start = $urandom_range(0, 7) == 0;
      ld_len = 16'($urandom_range(1, 3));
      tick;
      if (ld_valid && r) acc++;
      cyc++;
      chk("load_instr0", instr, 32'd0);
      chk("load_err", {31'd0, ld_err}, 32'd0);
      if (acc < 4 * n) begin
        chk("load_hold", {31'd0, cpu_hold}, 32'd1);
        chk("load_nodone", {31'd0, ld_done}, 32'd0);
      end else begin
        chk("done_pulse", {31'd0, ld_done}, 32'd1);
        chk("done_hold", {31'd0, cpu_hold}, 32'd1);
        chk("done_ready", {31'd0, ld_ready}, 32'd0);
      end
    end
    chk("load_timeout", {31'd0, acc >= total}, 32'd1);
    ld_valid = 0;
    ld_start = 0;
    rd_en = 0;
    for (int i = 0; i < acc / 4; i++) ref_mem[i] = w[i];
    exp_instr = 0;
    exp_oob = 0;
    if (rst_after < 0) begin
      tick;
      chk("done_clear", {31'd0, ld_done}, 32'd0);
      chk("hold_fall", {31'd0, cpu_hold}, 32'd0);
      chk("post_instr", instr, 32'd0);
    end else begin
      #1 rst = 1;
      #1;
      chk("rst_hold", {31'd0, cpu_hold}, 32'd0);
      chk("rst_ready", {31'd0, ld_ready}, 32'd0);
      chk("rst_done", {31'd0, ld_done}, 32'd0);
      chk("rst_instr", instr, 32'd0);
      tick;
      rst = 0;
      tick;
      chk("rst_idle_ready", {31'd0, ld_ready}, 32'd0);
    end
  endtask
  initial begin
    tick;
    tick;
    chk("reset_instr", instr, 32'd0);
    chk("reset_oob", {31'd0, rd_oob}, 32'd0);
    chk("reset_ready", {31'd0, ld_ready}, 32'd0);
    chk("reset_done", {31'd0, ld_done}, 32'd0);
    chk("reset_err", {31'd0, ld_err}, 32'd0);
    chk("reset_hold", {31'd0, cpu_hold}, 32'd0);
    rst = 0;
    tick;
    do_load(DEPTH, -1);
    do_read(0, 1);
    do_read(4, 1);
    do_read(8, 1);
    do_read(13, 1);
    do_read(32'(4 * DEPTH - 1), 1);
    do_load(2, -1);
    do_read(0, 1);
    do_read(4, 1);
    do_err(0);
    do_err(DEPTH + 1);
    do_err(65535);
    do_read(0, 1);
    do_read(4, 1);
    do_read(32'(4 * DEPTH), 1);
    do_read(0, 1);
    do_read(32'h8000_0000, 1);
    do_read(4, 0);
    do_load(3, 6);
    do_read(0, 1);
    do_read(4, 1);
    do_load(1, -1);
    do_read(0, 1);
    for (int k = 0; k < 300; k++) begin
      int sel;
      sel = $urandom_range(0, 19);
      if (sel == 0) do_load($urandom_range(1, 8), -1);
      else if (sel == 1) do_err($urandom_range(DEPTH + 1, 65535));
      else do_read(($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4 * DEPTH - 1)),
                   $urandom_range(0, 3) != 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
On-chip instruction memory that answers fetch-stage reads. It also provides a byte-serial load port so a host (UART/JTAG bridge) can write a program image into memory while the processor is frozen. It is the responder end of the fetch interface: fetch drives a byte PC, this block returns the 32-bit word one cycle later. cpu_hold feeds the fetch stage's stall, so the PC does not advance during a load.

Parameters:
ADDR_W, 10, word-address width; memory depth DEPTH = 2**ADDR_W 32-bit words
LEN_W, 16, width of the load word-count field

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
pc_addr  in  32  fetch byte address; word index = pc_addr[ADDR_W+1:2]
rd_en  in  1  fetch read request
instr  out  32  registered instruction word
rd_oob  out  1  registered; high with instr when the address is out of range
ld_start  in  1  one-cycle pulse, begins a load
ld_len  in  LEN_W  number of 32-bit words to load; sampled with ld_start
ld_byte  in  8  load data byte
ld_valid  in  1  ld_byte valid
ld_ready  out  1  block accepts ld_byte this cycle
ld_done  out  1  one-cycle pulse, load finished
ld_err  out  1  one-cycle pulse, load request rejected
cpu_hold  out  1  high while a load is in progress; drives fetch stall

Behaviour:
- Reset values: instr=0, rd_oob=0, ld_ready=0, ld_done=0, ld_err=0, cpu_hold=0, FSM=IDLE, wr_ptr=0, byte_cnt=0. Memory contents are not reset.
- Read path, latency 1:
  - On posedge with rd_en=1 and cpu_hold=0: instr <= mem[pc_addr[ADDR_W+1:2]], rd_oob <= 0.
  - If pc_addr[31:ADDR_W+2] != 0: instr <= 0 and rd_oob <= 1 instead.
  - pc_addr[1:0] are ignored.
  - rd_en=0: instr and rd_oob hold their value.
  - While cpu_hold=1: instr <= 0 and rd_oob <= 0 every cycle, regardless of rd_en.
- Loader FSM, states IDLE, LOAD, DONE:
  - IDLE, ld_start=1:
    - ld_len=0: ld_err pulses next cycle, stay IDLE.
    - ld_len > DEPTH: ld_err pulses next cycle, stay IDLE.
    - Otherwise: latch len, wr_ptr<=0, byte_cnt<=0, cpu_hold<=1, go to LOAD.
  - LOAD:
    - ld_ready=1 (registered; asserted the cycle after entry).
    - A byte is accepted when ld_valid && ld_ready.
    - Bytes assemble little-endian: byte_cnt 0 -> bits[7:0], ..., 3 -> bits[31:24].
    - On the 4th accepted byte: mem[wr_ptr] <= {ld_byte, assembled[23:0]} on the same edge, byte_cnt<=0, wr_ptr<=wr_ptr+1.
    - If that word was word len-1: ld_ready<=0, go to DONE.
    - ld_valid=0 stalls indefinitely with no timeout; partial bytes are retained.
  - DONE: ld_done=1 for exactly this cycle, cpu_hold=1 this cycle; next state IDLE, where cpu_hold<=0.
  - ld_start while in LOAD or DONE is ignored. No ld_err is raised.
- Handshake: ld_ready is never high outside LOAD. The host must not change ld_byte while ld_valid=1 && ld_ready=0.
- Simultaneous ld_start and rd_en in IDLE: the read completes normally that edge; cpu_hold rises on the same edge.
- Read/write collision cannot occur, because reads are suppressed while cpu_hold=1.
- Reset mid-load: FSM returns to IDLE, cpu_hold=0. Words already written remain in memory; the partial word is discarded.
- wr_ptr width is ADDR_W+1 so len=DEPTH completes without wrap.

Test Plan:
1. Preloaded mem[0..3]=A0,A1,A2,A3. Read pc_addr=0,4,8,13 with rd_en=1 back-to-back -> instr = A0,A1,A2,A3 each one cycle after its address; rd_oob=0 throughout.
2. ld_start with ld_len=2; bytes 13 00 00 00 93 00 10 00 with ld_valid gapped every other cycle -> mem[0]=0x00000013, mem[1]=0x00100093. ld_done pulses once. cpu_hold is high from the cycle after ld_start through the ld_done cycle, then low. Subsequent reads at 0 and 4 return these words.
3. ld_start with ld_len=0, then ld_start with ld_len=DEPTH+1 -> ld_err pulses each time, cpu_hold stays 0, memory unchanged.
4. Read pc_addr=4*DEPTH with rd_en=1 -> instr=0, rd_oob=1. Read pc_addr=0 next -> rd_oob=0.
5. Assert rst after 6 bytes of a 3-word load -> cpu_hold=0, ld_ready=0, FSM in IDLE. mem[0] holds the new word; mem[1] is unchanged.
6. ld_start pulsed again mid-load, and rd_en=1 during the load -> second start is ignored, load completes with the original len, instr=0 throughout the hold.
